// File: rtl/rmt_pkg.sv
//------------------------------------------------------------------------------
// Module      : rmt_pkg
// Description : Shared constants and the dispatcher state type for the
//               final-stage PHV path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rmt_pkg;

    localparam int PHV_LEN      = 1024;
    localparam int C_NUM_QUEUES = 4;
    localparam int QMAP_OFF     = 141;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 axis_clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/phv_mcast_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : phv_mcast_dispatcher
// Description : Holds one final-stage PHV until every queue selected by its
//               destination bitmap has taken it, then accepts the next one.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phv_mcast_dispatcher
    import rmt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    axis_clk,
    input  logic                    reset,
    input  logic [PHV_LEN-1:0]      phv_in,
    input  logic                    phv_in_valid,
    output logic                    phv_in_ready,
    output logic [PHV_LEN-1:0]      phv_out,
    output logic [C_NUM_QUEUES-1:0] phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0] phv_out_ready,
    output logic [CNT_WIDTH-1:0]    stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]    stat_nodest_cnt,
    output logic [CNT_WIDTH-1:0]    stat_timeout_cnt
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    disp_state_t             r_state;
    logic [C_NUM_QUEUES-1:0] r_pending;
    logic [PHV_LEN-1:0]      r_phv;
    logic [WAIT_W-1:0]       r_wait_cnt;

    logic [C_NUM_QUEUES-1:0] w_map;
    logic [C_NUM_QUEUES-1:0] w_pending_nx;
    logic                    w_accept;
    logic                    w_timeout;

    assign w_map        = phv_in[QMAP_OFF +: C_NUM_QUEUES];
    assign w_pending_nx = r_pending & ~(r_pending & phv_out_ready);

    // Loading is allowed in the very cycle the last outstanding queue completes.
    assign phv_in_ready = (r_state == IDLE) || (w_pending_nx == '0);
    assign w_accept     = phv_in_valid && phv_in_ready;

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == SEND) && !w_accept &&
                       (w_pending_nx != '0) &&
                       (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_phv      <= '0;
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_phv      <= phv_in;
            r_pending  <= w_map;
            r_wait_cnt <= '0;
            r_state    <= (w_map != '0) ? SEND : IDLE;
        end else if (r_state == SEND) begin
            if (w_pending_nx == '0) begin
                r_pending <= '0;
                r_state   <= IDLE;
            end else if (w_timeout) begin
                r_pending  <= '0;
                r_wait_cnt <= '0;
                r_state    <= IDLE;
            end else begin
                r_pending  <= w_pending_nx;
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign phv_out       = r_phv;
    assign phv_out_valid = r_pending;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .axis_clk (axis_clk),
        .reset    (reset),
        .inc      (w_accept && (w_map != '0)),
        .count    (stat_pkt_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_nodest_cnt (
        .axis_clk (axis_clk),
        .reset    (reset),
        .inc      (w_accept && (w_map == '0)),
        .count    (stat_nodest_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .axis_clk (axis_clk),
        .reset    (reset),
        .inc      (w_timeout),
        .count    (stat_timeout_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_phv_mcast_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : tb_phv_mcast_dispatcher
// Description : Directed and randomized self-checking bench for the dispatcher.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_phv_mcast_dispatcher;

    localparam int PHV_LEN = 1024;
    localparam int NQ      = 4;
    localparam int QOFF    = 141;
    localparam int TO      = 8;
    localparam int CW      = 32;

    logic                 axis_clk = 1'b0;
    logic                 reset;
    logic [PHV_LEN-1:0]   phv_in;
    logic                 phv_in_valid;
    logic                 phv_in_ready;
    logic [PHV_LEN-1:0]   phv_out;
    logic [NQ-1:0]        phv_out_valid;
    logic [NQ-1:0]        phv_out_ready;
    logic [CW-1:0]        stat_pkt_cnt;
    logic [CW-1:0]        stat_nodest_cnt;
    logic [CW-1:0]        stat_timeout_cnt;

    phv_mcast_dispatcher #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .axis_clk         (axis_clk),
        .reset            (reset),
        .phv_in           (phv_in),
        .phv_in_valid     (phv_in_valid),
        .phv_in_ready     (phv_in_ready),
        .phv_out          (phv_out),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready),
        .stat_pkt_cnt     (stat_pkt_cnt),
        .stat_nodest_cnt  (stat_nodest_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int errors = 0;

    // Reference: the held PHV, the set of queues still owed it, and how long it has waited.
    logic [NQ-1:0]      m_pend;
    logic [PHV_LEN-1:0] m_phv;
    int                 m_age;
    logic [CW-1:0]      m_pkt, m_nod, m_to;

    logic [PHV_LEN-1:0] exp_q [NQ][$];
    logic [PHV_LEN-1:0] got_q [NQ][$];

    always @(posedge axis_clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (phv_out_valid[i] === 1'b1 && phv_out_ready[i] === 1'b1) got_q[i].push_back(phv_out);
        end
    end

    task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (low 128 bits)", tag, obs[127:0], expv[127:0]);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [PHV_LEN-1:0] rnd_phv(input logic [NQ-1:0] map);
        logic [PHV_LEN-1:0] v;
        for (int k = 0; k < PHV_LEN / 32; k++) v[k*32 +: 32] = $urandom;
        v[QOFF +: NQ] = map;
        return v;
    endfunction

    // Copies owed to queues that never took them are withdrawn from the expected streams.
    task automatic drop_owed(input logic [NQ-1:0] owed);
        for (int i = 0; i < NQ; i++) begin
            if (owed[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_back());
        end
    endtask

    // One clock: inputs are already applied; check outputs, advance the reference, cross the edge.
    task automatic cyc();
        logic [NQ-1:0] owed;
        logic [NQ-1:0] map;
        logic          exp_ready;
        #1;
        owed      = m_pend & ~phv_out_ready;
        exp_ready = (owed == '0);
        map       = phv_in[QOFF +: NQ];
        chk("phv_out_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(m_pend));
        chk("phv_in_ready", PHV_LEN'(phv_in_ready), PHV_LEN'(exp_ready));
        chk("phv_out", phv_out, m_phv);
        chk("stat_pkt_cnt", PHV_LEN'(stat_pkt_cnt), PHV_LEN'(m_pkt));
        chk("stat_nodest_cnt", PHV_LEN'(stat_nodest_cnt), PHV_LEN'(m_nod));
        chk("stat_timeout_cnt", PHV_LEN'(stat_timeout_cnt), PHV_LEN'(m_to));
        if (reset) begin
            drop_owed(owed);
            m_pend = '0; m_phv = '0; m_age = 0;
            m_pkt = '0; m_nod = '0; m_to = '0;
        end else if (phv_in_valid && exp_ready) begin
            m_phv  = phv_in;
            m_pend = map;
            m_age  = 0;
            for (int i = 0; i < NQ; i++) if (map[i]) exp_q[i].push_back(phv_in);
            if (map != '0) m_pkt = sat_inc(m_pkt);
            else           m_nod = sat_inc(m_nod);
        end else if (m_pend != '0) begin
            if (owed == '0) begin
                m_pend = '0;
            end else if (m_age == TO - 1) begin
                drop_owed(owed);
                m_pend = '0;
                m_to   = sat_inc(m_to);
            end else begin
                m_pend = owed;
                m_age++;
            end
        end
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        phv_in_valid  = 1'b0;
        phv_out_ready = '0;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        phv_out_ready = '0;
        @(posedge axis_clk);
        #1;
        m_pend = '0; m_phv = '0; m_age = 0;
        m_pkt = '0; m_nod = '0; m_to = '0;
        reset = 1'b0;

        // Unicast back-to-back at full rate
        do_reset();
        for (int n = 0; n < 4; n++) begin
            phv_in = rnd_phv(4'b0001); phv_in_valid = 1'b1; phv_out_ready = 4'hF;
            cyc();
        end
        phv_in_valid = 1'b0;
        cyc();
        chk("t1_pkt_cnt", PHV_LEN'(stat_pkt_cnt), PHV_LEN'(4));

        // Multicast with one slow queue
        do_reset();
        phv_in = rnd_phv(4'b1010); phv_in_valid = 1'b1; phv_out_ready = 4'b0010;
        cyc();
        phv_in_valid = 1'b0;
        for (int n = 0; n < 6; n++) cyc();
        phv_out_ready = 4'b1010;
        #1;
        chk("t2_ready_on_last", PHV_LEN'(phv_in_ready), PHV_LEN'(1));
        cyc();
        cyc();

        // Zero bitmap is discarded
        do_reset();
        phv_in = rnd_phv(4'b0000); phv_in_valid = 1'b1; phv_out_ready = 4'hF;
        cyc();
        phv_in_valid = 1'b0;
        cyc();
        chk("t3_nodest_cnt", PHV_LEN'(stat_nodest_cnt), PHV_LEN'(1));
        chk("t3_no_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(0));

        // Timeout on a queue that never becomes ready
        do_reset();
        phv_in = rnd_phv(4'b0100); phv_in_valid = 1'b1; phv_out_ready = 4'b1011;
        cyc();
        phv_in_valid = 1'b0;
        for (int n = 0; n < 10; n++) cyc();
        chk("t4_timeout_cnt", PHV_LEN'(stat_timeout_cnt), PHV_LEN'(1));
        phv_in = rnd_phv(4'b0001); phv_in_valid = 1'b1; phv_out_ready = 4'hF;
        cyc();
        phv_in_valid = 1'b0;
        cyc();
        chk("t4_next_accepted", PHV_LEN'(stat_pkt_cnt), PHV_LEN'(2));

        // Broadcast drained one queue per cycle
        do_reset();
        phv_in = rnd_phv(4'b1111); phv_in_valid = 1'b1; phv_out_ready = 4'b0000;
        cyc();
        phv_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            phv_out_ready = 4'(1 << k);
            cyc();
        end
        cyc();
        chk("t5_pkt_cnt", PHV_LEN'(stat_pkt_cnt), PHV_LEN'(1));

        // Reset in the middle of a delivery
        do_reset();
        phv_in = rnd_phv(4'b0110); phv_in_valid = 1'b1; phv_out_ready = 4'b0000;
        cyc();
        phv_in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_valid_after_reset", PHV_LEN'(phv_out_valid), PHV_LEN'(0));

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [NQ-1:0] map;
            map           = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            phv_in        = rnd_phv(map);
            phv_in_valid  = ($urandom_range(0, 3) != 0);
            phv_out_ready = 4'($urandom | $urandom);
            reset         = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset        = 1'b0;
        phv_in_valid = 1'b0;
        phv_out_ready = 4'hF;
        cyc();
        cyc();

        for (int i = 0; i < NQ; i++) begin
            chk("sb_depth", PHV_LEN'(got_q[i].size()), PHV_LEN'(exp_q[i].size()));
            for (int j = 0; j < exp_q[i].size() && j < got_q[i].size(); j++) begin
                if (got_q[i][j] !== exp_q[i][j]) begin
                    chk("sb_order", got_q[i][j], exp_q[i][j]);
                    break;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
